// File: rtl/ramb_dp_param_if.sv
// Port bundle for ramb_dp_param (both access ports).
// COLL is present only when RAMB_DP_COLL_DETECT_EN is defined.
interface ramb_dp_param_if #(
  parameter int unsigned DATA_W = 1,
  parameter int unsigned ADDR_W = 12
);
  logic              ENA, WEA, RSTA;
  logic [ADDR_W-1:0] ADDRA;
  logic [DATA_W-1:0] DIA, DOA;
  logic              ENB, WEB, RSTB;
  logic [ADDR_W-1:0] ADDRB;
  logic [DATA_W-1:0] DIB, DOB;

`ifdef RAMB_DP_COLL_DETECT_EN
  logic COLL;

  modport master (
    output ENA, WEA, RSTA, ADDRA, DIA, ENB, WEB, RSTB, ADDRB, DIB,
    input  DOA, DOB, COLL
  );
  modport slave (
    input  ENA, WEA, RSTA, ADDRA, DIA, ENB, WEB, RSTB, ADDRB, DIB,
    output DOA, DOB, COLL
  );
`else
  modport master (
    output ENA, WEA, RSTA, ADDRA, DIA, ENB, WEB, RSTB, ADDRB, DIB,
    input  DOA, DOB
  );
  modport slave (
    input  ENA, WEA, RSTA, ADDRA, DIA, ENB, WEB, RSTB, ADDRB, DIB,
    output DOA, DOB
  );
`endif
endinterface

// File: rtl/ramb_dp_param.sv
// Parametrised single-clock true dual-port block RAM with per-port write mode and optional
// output register. Define RAMB_DP_COLL_DETECT_EN to add the registered COLL collision flag.
module ramb_dp_param #(
  parameter int unsigned       DATA_W       = 1,
  parameter int unsigned       ADDR_W       = 12,
  parameter string             WRITE_MODE_A = "WRITE_FIRST",
  parameter string             WRITE_MODE_B = "WRITE_FIRST",
  parameter int unsigned       DO_REG       = 0,
  parameter logic [DATA_W-1:0] SRVAL_A      = '0,
  parameter logic [DATA_W-1:0] SRVAL_B      = '0,
  parameter logic [DATA_W-1:0] INIT_VAL     = '0
) (
  input  logic           CLK,
  input  logic           RSTN,
  ramb_dp_param_if.slave bus
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  // Anything that is not READ_FIRST or NO_CHANGE behaves as WRITE_FIRST.
  localparam bit RdFirstA = (WRITE_MODE_A == "READ_FIRST");
  localparam bit NoChgA   = (WRITE_MODE_A == "NO_CHANGE");
  localparam bit RdFirstB = (WRITE_MODE_B == "READ_FIRST");
  localparam bit NoChgB   = (WRITE_MODE_B == "NO_CHANGE");

  logic [DATA_W-1:0] mem [Depth] = '{default: INIT_VAL};

  logic [DATA_W-1:0] rd_a, rd_b;
  logic [DATA_W-1:0] s1a_d, s1a_q;
  logic [DATA_W-1:0] s1b_d, s1b_q;

  // Reads see the pre-edge word, so a cross-port write/read returns the old data.
  assign rd_a = mem[bus.ADDRA];
  assign rd_b = mem[bus.ADDRB];

  always_ff @(posedge CLK) begin
    if (RSTN && bus.ENB && bus.WEB) mem[bus.ADDRB] <= bus.DIB;
    // Port A is assigned last so it wins a same-address write/write.
    if (RSTN && bus.ENA && bus.WEA) mem[bus.ADDRA] <= bus.DIA;
  end

  always_comb begin
    s1a_d = s1a_q;
    if (bus.ENA) begin
      if (bus.RSTA)                 s1a_d = SRVAL_A;
      else if (!bus.WEA || RdFirstA) s1a_d = rd_a;
      else if (!NoChgA)             s1a_d = bus.DIA;
    end
  end

  always_comb begin
    s1b_d = s1b_q;
    if (bus.ENB) begin
      if (bus.RSTB)                 s1b_d = SRVAL_B;
      else if (!bus.WEB || RdFirstB) s1b_d = rd_b;
      else if (!NoChgB)             s1b_d = bus.DIB;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      s1a_q <= SRVAL_A;
      s1b_q <= SRVAL_B;
    end else begin
      s1a_q <= s1a_d;
      s1b_q <= s1b_d;
    end
  end

  if (DO_REG != 0) begin : g_out_reg
    logic [DATA_W-1:0] s2a_q, s2b_q;

    // Second stage runs every cycle, independent of the port enables.
    always_ff @(posedge CLK) begin
      if (!RSTN) begin
        s2a_q <= SRVAL_A;
        s2b_q <= SRVAL_B;
      end else begin
        s2a_q <= s1a_q;
        s2b_q <= s1b_q;
      end
    end

    assign bus.DOA = s2a_q;
    assign bus.DOB = s2b_q;
  end else begin : g_out_direct
    assign bus.DOA = s1a_q;
    assign bus.DOB = s1b_q;
  end

`ifdef RAMB_DP_COLL_DETECT_EN
  logic coll_now;
  logic coll1_q;

  assign coll_now = RSTN && bus.ENA && bus.ENB && (bus.ADDRA == bus.ADDRB) &&
                    (bus.WEA || bus.WEB);

  always_ff @(posedge CLK) begin
    if (!RSTN) coll1_q <= 1'b0;
    else       coll1_q <= coll_now;
  end

  // The flag follows the same latency as read data.
  if (DO_REG != 0) begin : g_coll_reg
    logic coll2_q;

    always_ff @(posedge CLK) begin
      if (!RSTN) coll2_q <= 1'b0;
      else       coll2_q <= coll1_q;
    end

    assign bus.COLL = coll2_q;
  end else begin : g_coll_direct
    assign bus.COLL = coll1_q;
  end

`ifndef SYNTHESIS
  always_ff @(posedge CLK) begin
    if (coll_now) begin
      $display("%0t ramb_dp_param: %s collision at address 0x%0h", $time,
               (bus.WEA && bus.WEB) ? "write/write" : "write/read", bus.ADDRA);
    end
  end
`endif
`endif

endmodule

// File: tb/tb_ramb_dp_param.sv
// Scoreboard bench for ramb_dp_param: three instances (write-first, read-first, no-change with
// output register) share one stimulus stream; expected words are queued with a due cycle.
module tb_ramb_dp_param;

  logic       clk;
  logic       rstn;
  logic       ena, wea, rsta, enb, web, rstb;
  logic [3:0] addra, addrb;
  logic [7:0] dia, dib;

  typedef struct {
    string      tag;
    int         dut;
    int         port;
    logic [7:0] exp;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   vectors;
  int   miscompares;

  ramb_dp_param_if #(.DATA_W(8), .ADDR_W(4)) bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_drv
    assign bus[g].ENA   = ena;
    assign bus[g].WEA   = wea;
    assign bus[g].RSTA  = rsta;
    assign bus[g].ADDRA = addra;
    assign bus[g].DIA   = dia;
    assign bus[g].ENB   = enb;
    assign bus[g].WEB   = web;
    assign bus[g].RSTB  = rstb;
    assign bus[g].ADDRB = addrb;
    assign bus[g].DIB   = dib;
  end

  ramb_dp_param #(
    .DATA_W(8), .ADDR_W(4), .WRITE_MODE_A("WRITE_FIRST"), .WRITE_MODE_B("WRITE_FIRST"),
    .DO_REG(0), .SRVAL_A(8'hFF), .SRVAL_B(8'h96), .INIT_VAL(8'h3C)
  ) u_wf (.CLK(clk), .RSTN(rstn), .bus(bus[0]));

  ramb_dp_param #(
    .DATA_W(8), .ADDR_W(4), .WRITE_MODE_A("READ_FIRST"), .WRITE_MODE_B("READ_FIRST"),
    .DO_REG(0), .SRVAL_A(8'hFF), .SRVAL_B(8'h96), .INIT_VAL(8'h3C)
  ) u_rf (.CLK(clk), .RSTN(rstn), .bus(bus[1]));

  ramb_dp_param #(
    .DATA_W(8), .ADDR_W(4), .WRITE_MODE_A("NO_CHANGE"), .WRITE_MODE_B("WRITE_FIRST"),
    .DO_REG(1), .SRVAL_A(8'hFF), .SRVAL_B(8'h96), .INIT_VAL(8'h3C)
  ) u_nc (.CLK(clk), .RSTN(rstn), .bus(bus[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // port 0 = DO A, port 1 = DO B, port 2 = COLL
  function automatic logic [7:0] dout(int d, int p);
    logic [7:0] v;
    v = '0;
    case (d)
      0:       v = (p == 0) ? bus[0].DOA : bus[0].DOB;
      1:       v = (p == 0) ? bus[1].DOA : bus[1].DOB;
      default: v = (p == 0) ? bus[2].DOA : bus[2].DOB;
    endcase
`ifdef RAMB_DP_COLL_DETECT_EN
    if (p == 2) begin
      case (d)
        0:       v = {7'd0, bus[0].COLL};
        1:       v = {7'd0, bus[1].COLL};
        default: v = {7'd0, bus[2].COLL};
      endcase
    end
`endif
    return v;
  endfunction

  task automatic push(input string tag, input int d, input int p, input logic [7:0] v,
                      input int lat);
    exp_t e;
    e.tag  = tag;
    e.dut  = d;
    e.port = p;
    e.exp  = v;
    e.due  = cyc + lat;
    sb.push_back(e);
  endtask

  // Same word expected from all three instances, at each instance's read latency.
  task automatic push_all(input string tag, input int p, input logic [7:0] v);
    push(tag, 0, p, v, 1);
    push(tag, 1, p, v, 1);
    push(tag, 2, p, v, 2);
  endtask

  task automatic idle();
    ena = 0; wea = 0; rsta = 0; addra = '0; dia = '0;
    enb = 0; web = 0; rstb = 0; addrb = '0; dib = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    logic [7:0] act;
    rstn = 1'b0;
    for (int c = 0; c < 2; c++) begin
      idle();
      case (c)
        0: begin
          ena = 1; wea = 1; addra = 4'd0; dia = 8'h77;
          push_all("rst_doa", 0, 8'hFF);
          push_all("rst_dob", 1, 8'h96);
`ifdef RAMB_DP_COLL_DETECT_EN
          push_all("rst_coll", 2, 8'h00);
`endif
        end
        default: begin
          push("rst_s2_a", 2, 0, 8'hFF, 1);
          push("rst_s2_b", 2, 1, 8'h96, 1);
        end
      endcase
      step();
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due <= cyc) begin
          act = dout(sb[i].dut, sb[i].port);
          vectors++;
          if (sb[i].due != cyc || act !== sb[i].exp) begin
            miscompares++;
            $display("FAIL %s dut%0d port%0d: got %h expected %h", sb[i].tag, sb[i].dut,
                     sb[i].port, act, sb[i].exp);
          end
          sb.delete(i);
        end
      end
    end
    rstn = 1'b1;
  endtask

  task automatic test_init_read();
    logic [7:0] act;
    for (int c = 0; c < 2; c++) begin
      idle();
      if (c == 0) begin
        ena = 1; addra = 4'd0; enb = 1; addrb = 4'd15;
        push_all("init_a", 0, 8'h3C);
        push_all("init_b", 1, 8'h3C);
        push("pipe_old_a", 2, 0, 8'hFF, 1);
        push("pipe_old_b", 2, 1, 8'h96, 1);
      end
      step();
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due <= cyc) begin
          act = dout(sb[i].dut, sb[i].port);
          vectors++;
          if (sb[i].due != cyc || act !== sb[i].exp) begin
            miscompares++;
            $display("FAIL %s dut%0d port%0d: got %h expected %h", sb[i].tag, sb[i].dut,
                     sb[i].port, act, sb[i].exp);
          end
          sb.delete(i);
        end
      end
    end
  endtask

  task automatic test_write_read();
    logic [7:0] act;
    for (int c = 0; c < 3; c++) begin
      idle();
      case (c)
        0: begin
          ena = 1; wea = 1; addra = 4'd3; dia = 8'hA5;
          push("wr_wf_a", 0, 0, 8'hA5, 1);
          push("wr_rf_a", 1, 0, 8'h3C, 1);
          push("wr_nc_a", 2, 0, 8'h3C, 2);
        end
        1: begin
          enb = 1; addrb = 4'd3;
          push_all("rd_b", 1, 8'hA5);
          push("rd_b_old", 2, 1, 8'h3C, 1);
          push("hold_a", 0, 0, 8'hA5, 1);
        end
        default: ;
      endcase
      step();
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due <= cyc) begin
          act = dout(sb[i].dut, sb[i].port);
          vectors++;
          if (sb[i].due != cyc || act !== sb[i].exp) begin
            miscompares++;
            $display("FAIL %s dut%0d port%0d: got %h expected %h", sb[i].tag, sb[i].dut,
                     sb[i].port, act, sb[i].exp);
          end
          sb.delete(i);
        end
      end
    end
  endtask

  task automatic test_do_reg();
    logic [7:0] act;
    for (int c = 0; c < 2; c++) begin
      idle();
      if (c == 0) begin
        ena = 1; addra = 4'd3;
        push("dreg_edge1", 2, 0, 8'h3C, 1);
        push("dreg_edge2", 2, 0, 8'hA5, 2);
        push("dreg_lat1", 0, 0, 8'hA5, 1);
      end
      step();
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due <= cyc) begin
          act = dout(sb[i].dut, sb[i].port);
          vectors++;
          if (sb[i].due != cyc || act !== sb[i].exp) begin
            miscompares++;
            $display("FAIL %s dut%0d port%0d: got %h expected %h", sb[i].tag, sb[i].dut,
                     sb[i].port, act, sb[i].exp);
          end
          sb.delete(i);
        end
      end
    end
  endtask

  task automatic test_collision();
    logic [7:0] act;
    for (int c = 0; c < 4; c++) begin
      idle();
      case (c)
        0: begin
          ena = 1; wea = 1; addra = 4'd5; dia = 8'h11;
          enb = 1; web = 1; addrb = 4'd5; dib = 8'h22;
          push("ww_wf_a", 0, 0, 8'h11, 1);
          push("ww_wf_b", 0, 1, 8'h22, 1);
          push("ww_rf_a", 1, 0, 8'h3C, 1);
          push("ww_rf_b", 1, 1, 8'h3C, 1);
          push("ww_nc_a", 2, 0, 8'hA5, 2);
          push("ww_wf_b2", 2, 1, 8'h22, 2);
`ifdef RAMB_DP_COLL_DETECT_EN
          push_all("coll_ww", 2, 8'h01);
`endif
        end
        1: begin
          ena = 1; wea = 1; addra = 4'd5; dia = 8'h33;
          enb = 1; addrb = 4'd5;
          push_all("wr_old_b", 1, 8'h11);
          push("wr_wf_a33", 0, 0, 8'h33, 1);
          push("wr_rf_a33", 1, 0, 8'h11, 1);
`ifdef RAMB_DP_COLL_DETECT_EN
          push_all("coll_wr", 2, 8'h01);
`endif
        end
        2: begin
          ena = 1; addra = 4'd5; enb = 1; addrb = 4'd5;
          push_all("rr_a", 0, 8'h33);
          push_all("rr_b", 1, 8'h33);
`ifdef RAMB_DP_COLL_DETECT_EN
          push_all("coll_rr", 2, 8'h00);
`endif
        end
        default: ;
      endcase
      step();
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due <= cyc) begin
          act = dout(sb[i].dut, sb[i].port);
          vectors++;
          if (sb[i].due != cyc || act !== sb[i].exp) begin
            miscompares++;
            $display("FAIL %s dut%0d port%0d: got %h expected %h", sb[i].tag, sb[i].dut,
                     sb[i].port, act, sb[i].exp);
          end
          sb.delete(i);
        end
      end
    end
  endtask

  task automatic test_write_modes();
    logic [7:0] act;
    for (int c = 0; c < 4; c++) begin
      idle();
      case (c)
        0: begin
          ena = 1; wea = 1; addra = 4'd7; dia = 8'hC3;
        end
        1: begin
          ena = 1; wea = 1; addra = 4'd7; dia = 8'h5A;
          push("mode_wf", 0, 0, 8'h5A, 1);
          push("mode_rf", 1, 0, 8'hC3, 1);
          push("mode_nc1", 2, 0, 8'h33, 1);
          push("mode_nc2", 2, 0, 8'h33, 2);
        end
        2: begin
          enb = 1; addrb = 4'd7;
          push_all("mode_mem", 1, 8'h5A);
        end
        default: ;
      endcase
      step();
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due <= cyc) begin
          act = dout(sb[i].dut, sb[i].port);
          vectors++;
          if (sb[i].due != cyc || act !== sb[i].exp) begin
            miscompares++;
            $display("FAIL %s dut%0d port%0d: got %h expected %h", sb[i].tag, sb[i].dut,
                     sb[i].port, act, sb[i].exp);
          end
          sb.delete(i);
        end
      end
    end
  endtask

  task automatic test_port_reset();
    logic [7:0] act;
    for (int c = 0; c < 4; c++) begin
      idle();
      case (c)
        0: begin
          ena = 1; rsta = 1; wea = 1; addra = 4'd2; dia = 8'h07;
          enb = 1; rstb = 1; addrb = 4'd7;
          push_all("srst_a", 0, 8'hFF);
          push_all("srst_b", 1, 8'h96);
        end
        1: begin
          ena = 1; addra = 4'd2;
          push_all("srst_wr", 0, 8'h07);
        end
        2: begin
          rsta = 1; wea = 1; addra = 4'd2; dia = 8'h00;
          push_all("srst_dis", 0, 8'h07);
        end
        default: ;
      endcase
      step();
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due <= cyc) begin
          act = dout(sb[i].dut, sb[i].port);
          vectors++;
          if (sb[i].due != cyc || act !== sb[i].exp) begin
            miscompares++;
            $display("FAIL %s dut%0d port%0d: got %h expected %h", sb[i].tag, sb[i].dut,
                     sb[i].port, act, sb[i].exp);
          end
          sb.delete(i);
        end
      end
    end
  endtask

  task automatic test_rstn_mid();
    logic [7:0] act;
    for (int c = 0; c < 5; c++) begin
      idle();
      rstn = 1'b1;
      case (c)
        0: begin
          ena = 1; addra = 4'd7; enb = 1; addrb = 4'd3;
          push("pre_a", 0, 0, 8'h5A, 1);
          push("pre_b", 0, 1, 8'hA5, 1);
        end
        1: begin
          rstn = 1'b0;
          ena = 1; wea = 1; addra = 4'd3; dia = 8'hEE;
          push_all("mid_a", 0, 8'hFF);
          push_all("mid_b", 1, 8'h96);
          push("mid_s2_a", 2, 0, 8'hFF, 1);
          push("mid_s2_b", 2, 1, 8'h96, 1);
        end
        3: begin
          ena = 1; addra = 4'd3; enb = 1; addrb = 4'd7;
          push_all("kept_a", 0, 8'hA5);
          push_all("kept_b", 1, 8'h5A);
        end
        default: ;
      endcase
      step();
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due <= cyc) begin
          act = dout(sb[i].dut, sb[i].port);
          vectors++;
          if (sb[i].due != cyc || act !== sb[i].exp) begin
            miscompares++;
            $display("FAIL %s dut%0d port%0d: got %h expected %h", sb[i].tag, sb[i].dut,
                     sb[i].port, act, sb[i].exp);
          end
          sb.delete(i);
        end
      end
    end
    rstn = 1'b1;
  endtask

  initial begin
    cyc         = 0;
    vectors     = 0;
    miscompares = 0;
    rstn        = 1'b0;
    idle();
    test_reset();
    test_init_read();
    test_write_read();
    test_do_reg();
    test_collision();
    test_write_modes();
    test_port_reset();
    test_rstn_mid();
    while (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s dut%0d port%0d: never checked, expected %h", sb[0].tag, sb[0].dut,
               sb[0].port, sb[0].exp);
      void'(sb.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ramb_dp_param.md
Name: ramb_dp_param

Overview:
- Parametrised single-clock true dual-port block RAM.
- Successor to the fixed 4096x1 dual-port primitives. Adds:
  - configurable width and depth
  - per-port write mode
  - optional output pipeline register
  - defined cross-port collision resolution
- Used as a generic storage macro in datapath and buffer blocks.

Parameters:
- DATA_W, 1, data width of both ports in bits (1..64).
- ADDR_W, 12, address width; depth = 2**ADDR_W words.
- WRITE_MODE_A, "WRITE_FIRST", port A write behaviour on DOA: "WRITE_FIRST", "READ_FIRST" or "NO_CHANGE".
- WRITE_MODE_B, "WRITE_FIRST", same options for port B.
- DO_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2.
- SRVAL_A, 0, DATA_W value loaded into DOA on reset.
- SRVAL_B, 0, DATA_W value loaded into DOB on reset.
- INIT_VAL, 0, DATA_W value every memory word holds at time zero.

Ports:
- CLK  input  1  single clock; all activity on rising edge.
- RSTN  input  1  synchronous active-low global reset.
- ENA  input  1  port A enable.
- WEA  input  1  port A write enable; qualified by ENA.
- RSTA  input  1  port A synchronous output reset, active high; qualified by ENA.
- ADDRA  input  ADDR_W  port A address.
- DIA  input  DATA_W  port A write data.
- DOA  output  DATA_W  port A read data.
- ENB, WEB, RSTB, ADDRB, DIB, DOB: same as port A, for port B.
- COLL  output  1  collision flag; present only with the optional feature.

Behaviour:
- Reset (RSTN low at an edge):
  - DOA <= SRVAL_A, DOB <= SRVAL_B.
  - Both pipeline stages cleared to SRVAL; pending pipeline data discarded.
  - Memory writes suppressed. Memory contents are retained, not reinitialised.
  - First access is accepted on the edge after RSTN returns high.
- Memory array:
  - Holds INIT_VAL at time zero.
  - Written only on an edge where RSTN=1, ENx=1, WEx=1.
- Port disabled (ENx=0): DOx holds its value, no write, RSTx ignored.
- Read, DO_REG=0: DOx = mem[ADDRx] one edge after the access.
- Read, DO_REG=1:
  - Stage-1 register captures on the access edge.
  - DOx updates on the following edge; this second stage is always clocked, not gated by ENx.
- Write-mode effect on the port's own DOx during a write:
  - WRITE_FIRST: DOx <= DIx.
  - READ_FIRST: DOx <= old mem[ADDRx].
  - NO_CHANGE: DOx holds.
- Port output reset (RSTx=1 with ENx=1):
  - Stage-1 output loads SRVAL_x in place of read data.
  - Any write on the same edge still takes place.
- Cross-port collision: both ports enabled, ADDRA==ADDRB, at least one WE asserted.
  - Write/write: memory takes DIA (port A has priority); DIB is discarded.
  - Write/read: the reading port returns the old word (read-before-write across ports). The writing port follows its own write mode.
  - Read/read: no collision; both ports return the same word.
- Address compare uses the full ADDR_W bits; there is no aliasing.
- DATA_W and ADDR_W mismatches are not permitted; both ports share geometry.

Optional Feature:
- Macro: RAMB_DP_COLL_DETECT_EN.
- Defined:
  - COLL port exists, registered, reset to 0.
  - COLL = 1 for exactly one cycle, aligned with the access edge plus read latency, for every collision as defined above.
  - Simulation-only $display of time, address and collision type.
- Undefined:
  - No COLL port, no compare logic.
  - Collision resolution rules still apply unchanged.

Test Plan:
- DATA_W=8, ADDR_W=4, DO_REG=0: write 0xA5 to addr 3 on A, read addr 3 on B next cycle -> DOB=0xA5 one edge after the read.
- DO_REG=1: A reads addr 3 holding 0xA5 -> DOA still old at edge+1, DOA=0xA5 at edge+2.
- Same edge, A writes 0x11 and B writes 0x22 to addr 5 -> mem[5]=0x11, COLL=1 for one cycle. Same edge, A writes 0x33 and B reads addr 5 -> DOB=0x11 (old word).
- Per-mode check: WEA=1, DIA=0x5A to an address holding 0xC3 -> WRITE_FIRST DOA=0x5A, READ_FIRST DOA=0xC3, NO_CHANGE DOA unchanged.
- SRVAL_A=0xFF: RSTA=1, ENA=1, WEA=1, DIA=0x07 at addr 2 -> DOA=0xFF and mem[2]=0x07. Then RSTA=1 with ENA=0 -> DOA unchanged.
- Mid-read, DO_REG=1: RSTN=0 for one edge -> DOA=SRVAL_A, DOB=SRVAL_B, pipelined data lost, memory contents preserved. A write attempted during RSTN=0 does not modify memory.
